pit_cmd_loader: RTL
===================

PIT_CMD_LOADER -- requirements
Module: pit_cmd_loader

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, meaning the number of idle cycles allowed between bytes of one multi-byte command.
REQ-002 SHALL provide parameter RELOAD_RST, default 16'hFFFF, meaning the reset value of reload.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning a command byte is present on in_data.
REQ-006 SHALL have port in_data, input, 8, meaning a command or payload byte.
REQ-007 SHALL have port in_ready, output, 1, meaning a byte is accepted on a clk edge where in_valid and in_ready are both high.
REQ-008 SHALL have port reload, output, 16, meaning the timer reload value fed to the downstream timer core.
REQ-009 SHALL have port prescale, output, 4, meaning the timer clock divider select.
REQ-010 SHALL have port mode, output, 2, with 00 = one-shot, 01 = periodic and 10 = square wave.
REQ-011 SHALL have port timer_en, output, 1, meaning run enable to the timer.
REQ-012 SHALL have port load_pulse, output, 1, meaning a one-cycle strobe when reload changes.
REQ-013 SHALL have port cmd_err, output, 1, meaning a sticky error flag.
REQ-014 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-015 SHALL decode the command opcode as in_data[7:6]: 00 CLR, 01 WR_RELOAD, 10 WR_CTRL, 11 RUN.
REQ-016 SHALL implement FSM states IDLE, GET_LO, GET_HI and COMMIT.
REQ-017 SHALL move IDLE->GET_LO on acceptance of WR_RELOAD, GET_LO->GET_HI on acceptance of the low byte, and GET_HI->COMMIT on acceptance of the high byte.
REQ-018 SHALL always move COMMIT->IDLE after exactly one cycle.
REQ-019 SHALL hold the low byte in a shadow register; reload SHALL update atomically to {hi,lo} on the edge accepting the high byte, never byte-by-byte.
REQ-020 SHALL assert load_pulse for exactly the one cycle spent in COMMIT, and deassert it at all other times.
REQ-021 SHALL drive in_ready high in IDLE, GET_LO and GET_HI, and low in COMMIT.
REQ-022 SHALL, for WR_CTRL accepted in IDLE: if in_data[5:4] != 11, set mode=in_data[5:4] and prescale=in_data[3:0] on the accepting edge; if in_data[5:4] == 11, leave mode and prescale unchanged, set cmd_err, and remain in IDLE.
REQ-023 SHALL, for RUN accepted in IDLE, set timer_en=in_data[0] and remain in IDLE; in_data[5:1] SHALL be ignored.
REQ-024 SHALL, for CLR accepted in IDLE, clear cmd_err and change nothing else.
REQ-025 SHALL count cycles in GET_LO and GET_HI with no byte accepted; the count SHALL clear on every accepted byte and on entry to IDLE.
REQ-026 SHALL, when the count reaches TIMEOUT, return to IDLE, discard the shadow byte, leave reload unchanged, set cmd_err, and not pulse load_pulse.
REQ-027 SHALL give acceptance priority over timeout when a byte is accepted in the same cycle the count reaches TIMEOUT.
REQ-028 SHALL treat any byte accepted in GET_LO or GET_HI as payload, regardless of its opcode bits.
REQ-029 SHALL allow a WR_RELOAD whose {hi,lo} equals the current reload to still commit and pulse load_pulse.
REQ-030 SHALL size the timeout counter to hold TIMEOUT without wrap-around.
REQ-031 SHALL keep cmd_err set until CLR or reset, even when later commands succeed.
REQ-032 SHALL drive busy high in GET_LO, GET_HI and COMMIT.

Reset
REQ-033 SHALL, while rst is high, immediately force state=IDLE, reload=RELOAD_RST, prescale=0, mode=00, timer_en=0, load_pulse=0, cmd_err=0, busy=0, in_ready=1, and shadow and counter to 0.
REQ-034 SHALL abort any partial command when rst asserts mid-sequence, with no commit after release.
REQ-035 SHALL accept a byte on the first rising clk edge after rst deasserts.

Verification
REQ-036 Bench SHALL cover: after reset, send 0x40, 0x34, 0x12 back-to-back -> reload=0x1234, load_pulse high for 1 cycle, in_ready low in that same cycle, busy low next cycle.
REQ-037 Bench SHALL cover: send 0x40, 0x78, then no byte for 255 cycles -> return to IDLE, cmd_err=1, reload=0xFFFF, no load_pulse; then send 0x00 -> cmd_err=0.
REQ-038 Bench SHALL cover: send 0x95 -> mode=01, prescale=5; then send 0xB3 -> mode and prescale unchanged, cmd_err=1.
REQ-039 Bench SHALL cover: send 0xC1 -> timer_en=1; then send 0xC0 -> timer_en=0; neither causes a load_pulse.
REQ-040 Bench SHALL cover: send 0x40, 0xAA, then assert rst mid-sequence, release, and send 0x55 -> no commit, reload=0xFFFF, and 0x55 decodes as WR_RELOAD.
REQ-041 Bench SHALL cover: high byte accepted exactly on the cycle the counter reaches TIMEOUT -> commit occurs and cmd_err stays 0.

Source files
------------

// File: rtl/pit_cmd_loader.sv
// pit_cmd_loader: byte-serial command decoder that programs a PIT-style timer.
// Opcode in bits [7:6]: CLR clears the error flag, WR_RELOAD takes two
// payload bytes (lo, hi), WR_CTRL sets mode/prescale and RUN sets timer_en.
// reload only changes as a whole 16-bit word, which is followed by one COMMIT
// cycle that strobes load_pulse.
module pit_cmd_loader #(
    parameter int          TIMEOUT    = 255,
    parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] reload,
    output logic [3:0]  prescale,
    output logic [1:0]  mode,
    output logic        timer_en,
    output logic        load_pulse,
    output logic        cmd_err,
    output logic        busy
);

    // The counter has to be able to hold TIMEOUT itself, so no wrap is possible.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_LO = 2'd1,
        GET_HI = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [1:0] OP_CLR    = 2'b00;
    localparam logic [1:0] OP_RELOAD = 2'b01;
    localparam logic [1:0] OP_CTRL   = 2'b10;
    localparam logic [1:0] OP_RUN    = 2'b11;

    state_t           state_q, state_d;
    logic [15:0]      reload_q, reload_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [3:0]       prescale_q, prescale_d;
    logic [1:0]       mode_q, mode_d;
    logic             timer_en_q, timer_en_d;
    logic             cmd_err_q, cmd_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // Outputs are direct decodes of the state, so reset forces them immediately.
    assign in_ready   = (state_q != COMMIT);
    assign busy       = (state_q != IDLE);
    assign load_pulse = (state_q == COMMIT);
    assign accept     = in_valid && in_ready;

    assign reload   = reload_q;
    assign prescale = prescale_q;
    assign mode     = mode_q;
    assign timer_en = timer_en_q;
    assign cmd_err  = cmd_err_q;

    // Next-state logic: command decode in IDLE, payload capture and timeout in GET_*.
    always_comb begin
        state_d    = state_q;
        reload_d   = reload_q;
        shadow_d   = shadow_q;
        prescale_d = prescale_q;
        mode_d     = mode_q;
        timer_en_d = timer_en_q;
        cmd_err_d  = cmd_err_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    case (in_data[7:6])
                        OP_CLR:    cmd_err_d = 1'b0;
                        OP_RELOAD: state_d   = GET_LO;
                        OP_CTRL: begin
                            // Mode 11 is reserved: reject the whole command.
                            if (in_data[5:4] == 2'b11) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                mode_d     = in_data[5:4];
                                prescale_d = in_data[3:0];
                            end
                        end
                        OP_RUN:    timer_en_d = in_data[0];
                        default:   ;
                    endcase
                end
            end
            GET_LO, GET_HI: begin
                // A byte arriving on the expiry cycle still counts.
                if (accept) begin
                    cnt_d = '0;
                    if (state_q == GET_LO) begin
                        shadow_d = in_data;
                        state_d  = GET_HI;
                    end else begin
                        reload_d = {in_data, shadow_q};
                        state_d  = COMMIT;
                    end
                end else if (cnt_q == TO_VAL) begin
                    state_d   = IDLE;
                    shadow_d  = '0;
                    cnt_d     = '0;
                    cmd_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            reload_q   <= RELOAD_RST;
            shadow_q   <= '0;
            prescale_q <= '0;
            mode_q     <= '0;
            timer_en_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            reload_q   <= reload_d;
            shadow_q   <= shadow_d;
            prescale_q <= prescale_d;
            mode_q     <= mode_d;
            timer_en_q <= timer_en_d;
            cmd_err_q  <= cmd_err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
